// File: rtl/floo_vc_pkg.sv
// floo_vc_pkg: shared VC index and credit types plus default port sizing.
package floo_vc_pkg;
  localparam int unsigned NumVCDefault = 4;
  localparam int unsigned VCDepthDefault = 3;

  function automatic int unsigned idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int unsigned VCIdxWDefault = idx_w(NumVCDefault);

  typedef logic [VCIdxWDefault-1:0] vc_idx_t;

  typedef struct packed {
    logic    valid;
    vc_idx_t id;
  } credit_t;
endpackage

// File: rtl/floo_vc_fifo.sv
// floo_vc_fifo: single-VC circular flit buffer; depth need not be a power of two.
module floo_vc_fifo #(
  parameter int unsigned Depth = 3,
  parameter type flit_t = logic
) (
  input  logic  clk_i,
  input  logic  rst_ni,
  input  logic  push_i,
  input  flit_t data_i,
  input  logic  pop_i,
  output logic  full_o,
  output logic  empty_o,
  output flit_t head_o
);
  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int unsigned CntW = $clog2(Depth + 1);

  flit_t           r_mem [Depth];
  logic [PtrW-1:0] r_rptr, r_wptr;
  logic [CntW-1:0] r_count;
  logic            w_push, w_pop;

  assign empty_o = (r_count == '0);
  assign full_o  = (r_count == CntW'(Depth));
  assign head_o  = r_mem[r_rptr];
  assign w_pop   = pop_i && !empty_o;
  // A same-cycle pop frees the slot, so a push into a full buffer still lands.
  assign w_push  = push_i && (!full_o || w_pop);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_rptr  <= '0;
      r_wptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= (r_wptr == PtrW'(Depth - 1)) ? '0 : r_wptr + 1'b1;
      if (w_pop) r_rptr <= (r_rptr == PtrW'(Depth - 1)) ? '0 : r_rptr + 1'b1;
      r_count <= r_count + CntW'(w_push) - CntW'(w_pop);
    end
  end

  always_ff @(posedge clk_i) begin
    if (w_push) r_mem[r_wptr] <= data_i;
  end
endmodule

// File: rtl/floo_vc_input_port.sv
// floo_vc_input_port: per-VC input buffering with registered credit return
// and overflow error pulse.
module floo_vc_input_port
  import floo_vc_pkg::*;
#(
  parameter int unsigned NumVC   = NumVCDefault,
  parameter int unsigned VCDepth = VCDepthDefault,
  parameter type flit_t          = logic,
  parameter int unsigned VCIdxW  = idx_w(NumVC)
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    valid_i,
  input  flit_t                   flit_i,
  input  logic [VCIdxW-1:0]       vc_id_i,
  output logic [NumVC-1:0]        vc_valid_o,
  output flit_t [NumVC-1:0]       vc_data_o,
  input  logic                    read_enable_i,
  input  logic [VCIdxW-1:0]       read_vc_id_i,
  output logic                    credit_valid_o,
  output logic [VCIdxW-1:0]       credit_id_o,
  output logic                    overflow_o
);
  typedef struct packed {
    logic              valid;
    logic [VCIdxW-1:0] id;
  } cred_t;

  logic [NumVC-1:0] w_full, w_empty, w_hit, w_rsel, w_pop_ok, w_bad;
  logic             w_read_ok, w_overflow;
  cred_t            r_credit;
  logic             r_overflow;

  for (genvar v = 0; v < NumVC; v++) begin : g_vc
    assign w_hit[v]    = (vc_id_i == VCIdxW'(v));
    assign w_rsel[v]   = (read_vc_id_i == VCIdxW'(v));
    assign w_pop_ok[v] = read_enable_i && w_rsel[v] && !w_empty[v];
    assign w_bad[v]    = valid_i && w_hit[v] && w_full[v] && !(read_enable_i && w_rsel[v]);
    floo_vc_fifo #(.Depth(VCDepth), .flit_t(flit_t)) u_fifo (
      .clk_i  (clk_i),
      .rst_ni (rst_ni),
      .push_i (valid_i && w_hit[v]),
      .data_i (flit_i),
      .pop_i  (read_enable_i && w_rsel[v]),
      .full_o (w_full[v]),
      .empty_o(w_empty[v]),
      .head_o (vc_data_o[v])
    );
  end

  assign vc_valid_o = ~w_empty;
  assign w_read_ok  = |w_pop_ok;
  // No matching VC means the index is out of range.
  assign w_overflow = valid_i && (~|w_hit || |w_bad);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_credit   <= '0;
      r_overflow <= 1'b0;
    end else begin
      r_credit   <= '{valid: w_read_ok, id: w_read_ok ? read_vc_id_i : '0};
      r_overflow <= w_overflow;
    end
  end

  assign credit_valid_o = r_credit.valid;
  assign credit_id_o    = r_credit.id;
  assign overflow_o     = r_overflow;
endmodule

// File: tb/tb_floo_vc_input_port.sv
// tb_floo_vc_input_port: directed checks of buffering, credits, overflow,
// wrap-around and asynchronous reset for a 4-VC, depth-3 port.
module tb_floo_vc_input_port;
  typedef logic [7:0] flit_t;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             valid;
  flit_t            flit;
  logic [1:0]       vc_id;
  logic [3:0]       vc_valid;
  flit_t [3:0]      vc_data;
  logic             re;
  logic [1:0]       rvc;
  logic             cr_valid;
  logic [1:0]       cr_id;
  logic             ovf;

  int total = 0;
  int bad = 0;

  floo_vc_input_port #(.NumVC(4), .VCDepth(3), .flit_t(flit_t)) dut (
    .clk_i         (clk),
    .rst_ni        (rst_n),
    .valid_i       (valid),
    .flit_i        (flit),
    .vc_id_i       (vc_id),
    .vc_valid_o    (vc_valid),
    .vc_data_o     (vc_data),
    .read_enable_i (re),
    .read_vc_id_i  (rvc),
    .credit_valid_o(cr_valid),
    .credit_id_o   (cr_id),
    .overflow_o    (ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input logic v, input logic [1:0] id, input flit_t f,
                     input logic r, input logic [1:0] rid);
    valid = v; vc_id = id; flit = f; re = r; rvc = rid;
    @(posedge clk);
    #1;
  endtask

  initial begin
    flit_t q0[$], q3[$];
    int nread, ncred;
    rst_n = 1'b0;
    valid = 1'b0; vc_id = '0; flit = '0; re = 1'b0; rvc = '0;
    @(posedge clk);
    @(posedge clk);
    #1;
    chk("rst_vc_valid", 32'(vc_valid), 32'h0);
    chk("rst_credit", 32'(cr_valid), 32'h0);
    chk("rst_credit_id", 32'(cr_id), 32'h0);
    chk("rst_overflow", 32'(ovf), 32'h0);
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      cyc(0, 0, 0, 0, 0);
      chk("idle_credit", 32'(cr_valid), 32'h0);
      chk("idle_overflow", 32'(ovf), 32'h0);
      chk("idle_vc_valid", 32'(vc_valid), 32'h0);
    end

    // three flits through VC2
    cyc(1, 2, 8'hA1, 0, 0);
    chk("vc2_valid_rise", 32'(vc_valid), 32'h4);
    chk("vc2_head0", 32'(vc_data[2]), 32'hA1);
    chk("vc2_nocredit", 32'(cr_valid), 32'h0);
    cyc(1, 2, 8'hA2, 0, 0);
    chk("vc2_head1", 32'(vc_data[2]), 32'hA1);
    cyc(1, 2, 8'hA3, 0, 0);
    chk("vc2_head2", 32'(vc_data[2]), 32'hA1);
    cyc(0, 0, 0, 0, 0);
    chk("vc2_idle_credit", 32'(cr_valid), 32'h0);
    cyc(0, 0, 0, 1, 2);
    chk("vc2_rd1_head", 32'(vc_data[2]), 32'hA2);
    chk("vc2_rd1_cr", 32'(cr_valid), 32'h1);
    chk("vc2_rd1_id", 32'(cr_id), 32'h2);
    cyc(0, 0, 0, 1, 2);
    chk("vc2_rd2_head", 32'(vc_data[2]), 32'hA3);
    chk("vc2_rd2_cr", 32'(cr_valid), 32'h1);
    chk("vc2_rd2_id", 32'(cr_id), 32'h2);
    cyc(0, 0, 0, 1, 2);
    chk("vc2_fall", 32'(vc_valid), 32'h0);
    chk("vc2_rd3_cr", 32'(cr_valid), 32'h1);
    chk("vc2_rd3_id", 32'(cr_id), 32'h2);
    cyc(0, 0, 0, 0, 0);
    chk("vc2_cr_end", 32'(cr_valid), 32'h0);

    // empty-VC read returns no credit
    cyc(0, 0, 0, 1, 1);
    cyc(0, 0, 0, 0, 0);
    chk("empty_rd_cr", 32'(cr_valid), 32'h0);

    // full VC1: fourth write dropped
    cyc(1, 1, 8'hB1, 0, 0);
    cyc(1, 1, 8'hB2, 0, 0);
    cyc(1, 1, 8'hB3, 0, 0);
    chk("vc1_filled", 32'(vc_valid), 32'h2);
    chk("vc1_no_ovf", 32'(ovf), 32'h0);
    cyc(1, 1, 8'hB4, 0, 0);
    chk("vc1_ovf_pulse", 32'(ovf), 32'h1);
    chk("vc1_ovf_head", 32'(vc_data[1]), 32'hB1);
    cyc(0, 0, 0, 0, 0);
    chk("vc1_ovf_clear", 32'(ovf), 32'h0);
    chk("vc1_head_kept", 32'(vc_data[1]), 32'hB1);

    // full VC1 with simultaneous read: write accepted
    cyc(1, 1, 8'hC1, 1, 1);
    chk("vc1_wr_rd_ovf", 32'(ovf), 32'h0);
    chk("vc1_wr_rd_head", 32'(vc_data[1]), 32'hB2);
    chk("vc1_wr_rd_cr", 32'(cr_valid), 32'h1);
    chk("vc1_wr_rd_id", 32'(cr_id), 32'h1);
    cyc(0, 0, 0, 1, 1);
    chk("vc1_drain1", 32'(vc_data[1]), 32'hB3);
    cyc(0, 0, 0, 1, 1);
    chk("vc1_drain2", 32'(vc_data[1]), 32'hC1);
    chk("vc1_drain2_v", 32'(vc_valid), 32'h2);
    cyc(0, 0, 0, 1, 1);
    chk("vc1_drained", 32'(vc_valid), 32'h0);

    // wrap-around through VC0 at full rate
    cyc(1, 0, 8'hD0, 0, 0);
    chk("wrap_head0", 32'(vc_data[0]), 32'hD0);
    for (int i = 1; i < 10; i++) begin
      cyc(1, 0, 8'hD0 + 8'(i), 1, 0);
      chk("wrap_head", 32'(vc_data[0]), 32'(8'hD0 + 8'(i)));
      chk("wrap_cr", 32'(cr_valid), 32'h1);
      chk("wrap_valid", 32'(vc_valid), 32'h1);
    end
    cyc(0, 0, 0, 1, 0);
    chk("wrap_empty", 32'(vc_valid), 32'h0);
    chk("wrap_last_cr", 32'(cr_valid), 32'h1);

    // random traffic: writes on one of VC0/VC3, reads on the other
    nread = 0; ncred = 0;
    for (int i = 0; i < 1000; i++) begin
      logic [1:0] w, r;
      logic wv, rv, exp_cr;
      w = $urandom_range(0, 1) ? 2'd3 : 2'd0;
      r = (w == 2'd0) ? 2'd3 : 2'd0;
      wv = $urandom_range(0, 1) && (((w == 0) ? q0.size() : q3.size()) < 3);
      rv = $urandom_range(0, 1);
      exp_cr = rv && (((r == 0) ? q0.size() : q3.size()) > 0);
      if (exp_cr) begin
        if (r == 0) void'(q0.pop_front()); else void'(q3.pop_front());
        nread++;
      end
      if (wv) begin
        if (w == 0) q0.push_back(8'(i)); else q3.push_back(8'(i));
      end
      cyc(wv, w, 8'(i), rv, r);
      if (cr_valid) ncred++;
      chk("rnd_cr", 32'(cr_valid), 32'(exp_cr));
      if (exp_cr) chk("rnd_cr_id", 32'(cr_id), 32'(r));
      chk("rnd_ovf", 32'(ovf), 32'h0);
      chk("rnd_v0", 32'(vc_valid[0]), 32'(q0.size() != 0));
      chk("rnd_v3", 32'(vc_valid[3]), 32'(q3.size() != 0));
      if (q0.size() != 0) chk("rnd_d0", 32'(vc_data[0]), 32'(q0[0]));
      if (q3.size() != 0) chk("rnd_d3", 32'(vc_data[3]), 32'(q3[0]));
    end
    chk("rnd_cred_count", 32'(ncred), 32'(nread));

    // asynchronous reset mid-burst
    rst_n = 1'b0;
    #1;
    chk("arst_clear", 32'(vc_valid), 32'h0);
    cyc(0, 0, 0, 0, 0);
    rst_n = 1'b1;
    cyc(1, 3, 8'hE1, 0, 0);
    cyc(1, 3, 8'hE2, 0, 0);
    chk("burst_two", 32'(vc_valid), 32'h8);
    valid = 1'b0; re = 1'b1; rvc = 2'd3;
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", 32'(vc_valid), 32'h0);
    chk("mid_rst_cr", 32'(cr_valid), 32'h0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    re = 1'b0;
    cyc(0, 0, 0, 0, 0);
    chk("post_rst_cr", 32'(cr_valid), 32'h0);
    chk("post_rst_valid", 32'(vc_valid), 32'h0);
    cyc(0, 0, 0, 0, 0);
    chk("post_rst_cr2", 32'(cr_valid), 32'h0);
    cyc(1, 3, 8'hF1, 0, 0);
    chk("fresh_valid", 32'(vc_valid), 32'h8);
    chk("fresh_head", 32'(vc_data[3]), 32'hF1);
    cyc(0, 0, 0, 1, 3);
    chk("fresh_cr", 32'(cr_valid), 32'h1);
    chk("fresh_cr_id", 32'(cr_id), 32'h3);
    chk("fresh_empty", 32'(vc_valid), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/floo_vc_input_port.md
# floo_vc_input_port

Parametrised input port for the FlooNoC virtual-channel router. It buffers incoming flits in one independent FIFO per virtual channel and presents every VC's head flit to local switch allocation. It dequeues one VC per cycle on allocator grant and returns one credit per dequeue to the upstream output-port credit counter. It sits between the link and the per-input local SA stage, replacing ad-hoc single-VC input buffers.

## Interface
Parameters:
- NumVC, 4: number of virtual channels, ≥1.
- VCDepth, 3: flit slots per VC, ≥1; upstream credit counters are initialised to this value.
- flit_t, logic: flit payload type.
- VCIdxW, derived: $clog2(NumVC), minimum 1.

Ports:
- clk_i  in  1  clock; one clock domain.
- rst_ni  in  1  reset, asynchronous, active-low.
- valid_i  in  1  incoming flit valid; no ready, credit-based flow control.
- flit_i  in  flit_t  incoming flit.
- vc_id_i  in  VCIdxW  target VC of the incoming flit.
- vc_valid_o  out  NumVC  per-VC non-empty.
- vc_data_o  out  NumVC×flit_t  per-VC head flit.
- read_enable_i  in  1  dequeue strobe from local SA.
- read_vc_id_i  in  VCIdxW  VC to dequeue.
- credit_valid_o  out  1  one credit returned upstream.
- credit_id_o  out  VCIdxW  VC of the returned credit.
- overflow_o  out  1  one-cycle error pulse: a write targeted a full VC.

## Operation
- Per VC: circular buffer of VCDepth entries with read pointer, write pointer and occupancy count (0..VCDepth). Pointers wrap from VCDepth−1 to 0; VCDepth need not be a power of two.
- Write: valid_i && vc_id_i<NumVC && count<VCDepth stores flit_i at the write pointer, advances the pointer and increments count.
- Full VC: the write is dropped, all state is unchanged and overflow_o pulses on the next cycle. This is a protocol error; the bench flags it.
- vc_id_i ≥ NumVC: the write is dropped and overflow_o pulses.
- Read: read_enable_i && read_vc_id_i<NumVC && that VC is non-empty advances the read pointer, decrements count and schedules a credit.
- Empty VC or out-of-range read_vc_id_i: the read is ignored and no credit is returned. The bench flags this as an assertion.
- Simultaneous write and read on the same non-empty VC, including a full one: both happen, count is unchanged and no overflow occurs, because the slot is freed in the same cycle.
- Simultaneous write and read on the same empty VC: the read is ignored and the write is accepted.
- Writes and reads on different VCs are independent.
- vc_valid_o[v] = (count[v]≠0). vc_data_o[v] = the entry at the read pointer. Both are driven straight from registers; there is no write-to-output bypass.
- Credit conservation: credits returned equal flits dequeued; accepted flits minus returned credits equal the total occupancy.

## Timing
- Reset (rst_ni low, asynchronous): all counts and pointers go to 0.
  - vc_valid_o = 0, credit_valid_o = 0, credit_id_o = 0, overflow_o = 0.
  - Buffer contents are not reset; vc_data_o is don't-care while the matching vc_valid_o is 0.
  - Reset mid-traffic discards all stored flits; no credits are issued for them.
- Write latency: a flit written in cycle t makes vc_valid_o/vc_data_o visible in cycle t+1.
- Read: the dequeue takes effect at the clock edge ending cycle t. The new head (or vc_valid_o=0) is visible in t+1.
- Credit: credit_valid_o and credit_id_o are registered and assert in cycle t+1 for a read in cycle t. At most one credit per cycle.
- Overflow: overflow_o is registered and asserts in cycle t+1 for a bad write in cycle t.
- Throughput: one write and one read per cycle sustained. A VCDepth of at least the credit round-trip sustains full rate on one VC.

## Structure
- Shared package floo_vc_pkg holds:
  - the vc-index typedef;
  - the credit struct {valid, id}, so router and credit counters share it;
  - default NumVC/VCDepth constants.
- Sub-module floo_vc_fifo: a single-VC circular buffer with push, pop, full, empty and head, parametrised on VCDepth and flit_t.
  - floo_vc_input_port instantiates NumVC of them with generate.
  - The top level adds write decode, read decode, the credit register and the overflow register.

## Test plan
- Reset then idle, NumVC=4, VCDepth=3: all outputs 0; after 10 cycles no credit and no overflow.
- Write flits 0xA1, 0xA2, 0xA3 to VC2 in cycles 0–2, then read VC2 in cycles 4–6:
  - vc_valid_o[2] rises in cycle 1;
  - heads appear in the order A1, A2, A3;
  - credit_id_o=2 pulses in cycles 5–7;
  - vc_valid_o[2] falls in cycle 7.
- Fill VC1 to 3 flits, then a 4th write with no read: the flit is dropped, overflow_o=1 for exactly one cycle and the head is unchanged.
- Repeat with a simultaneous read on VC1: the write is accepted, count stays 3 and overflow_o stays 0.
- Interleave random writes on VC0/VC3 with reads on the other VC, for 1000 cycles:
  - per-VC FIFO order is preserved;
  - credits match reads one-to-one;
  - no credit is issued for empty-VC reads.
- Wrap-around with VCDepth=3 (non-power-of-two): push and pop 10 flits through VC0 at full rate; the data order is correct across pointer wraps.
- Assert rst_ni mid-burst with 2 flits in VC3: vc_valid_o clears asynchronously, and after release the port behaves as fresh with no stale credits.
